// File: rtl/hyper_lsab_dram_pkg.sv
// hyper_lsab_dram_pkg: shared types and geometry for the LSAB<->DRAM command sequencer.
package hyper_lsab_dram_pkg;

  localparam int unsigned PAGE_BITS  = 12;
  localparam int unsigned PAGE_WORDS = 1 << PAGE_BITS;
  localparam int unsigned LEN_W      = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    WSTART = 2'd2,
    WBUSY  = 2'd3
  } state_t;

endpackage

// File: rtl/hyper_lsab_dram_clip.sv
// hyper_lsab_dram_clip: clips a burst so it never crosses the end of the open DRAM page.
module hyper_lsab_dram_clip
  import hyper_lsab_dram_pkg::*;
#(
  parameter int unsigned COL_W = PAGE_BITS,
  parameter int unsigned CNT_W = LEN_W
) (
  input  logic [COL_W-1:0] col,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] req,
  output logic             clipped
);

  localparam int unsigned RW = COL_W + 1;

  logic [RW-1:0] room;
  logic [RW-1:0] len_ext;

  // Words left in the page from col, compared against the requested length.
  always_comb begin
    room    = (RW'(1) << COL_W) - RW'(col);
    len_ext = RW'(len);
    clipped = (len_ext > room);
    req     = clipped ? room[CNT_W-1:0] : len;
  end

endmodule

// File: rtl/hyper_lsab_dram_ctrl.sv
// hyper_lsab_dram_ctrl: sequences one CPU block-transfer request into an MCU page-open
// handshake and a single page-clipped burst to the LSAB<->DRAM mover.
// Optional watchdog on the ALIGN/WSTART waits: define HYPER_LSAB_DRAM_TIMEOUT_EN.
module hyper_lsab_dram_ctrl #(
  parameter int unsigned PAGE_BITS   = hyper_lsab_dram_pkg::PAGE_BITS,
  parameter int unsigned LEN_W       = hyper_lsab_dram_pkg::LEN_W,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   GO,
  input  logic [LEN_W-1:0]       BLOCK_LENGTH,
  input  logic [31:0]            NEW_ADDR,
  input  logic [1:0]             NEW_SECTION,
  output logic [31:0]            OLD_ADDR,
  output logic                   READY,
  output logic                   RESTART_OP,
  output logic [LEN_W-1:0]       COUNT_SENT,
  output logic [PAGE_BITS-1:0]   BLCK_START,
  output logic [LEN_W-1:0]       BLCK_COUNT_REQ,
  output logic                   BLCK_ISSUE,
  output logic [1:0]             BLCK_SECTION,
  input  logic [LEN_W-1:0]       BLCK_COUNT_SENT,
  input  logic                   BLCK_WORKING,
  output logic [31-PAGE_BITS:0]  MCU_PAGE_ADDR,
  output logic                   MCU_REQUEST_ALIGN,
  input  logic                   MCU_GRANT_ALIGN
);

  import hyper_lsab_dram_pkg::state_t;
  import hyper_lsab_dram_pkg::IDLE;
  import hyper_lsab_dram_pkg::ALIGN;
  import hyper_lsab_dram_pkg::WSTART;
  import hyper_lsab_dram_pkg::WBUSY;

  state_t                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [1:0]             sect_q, sect_d;
  logic [31:0]            old_q, old_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic                   restart_q, restart_d;
  logic                   ready_q, ready_d;
  logic                   mreq_q, mreq_d;
  logic [31-PAGE_BITS:0]  page_q, page_d;
  logic                   issue_q, issue_d;
  logic [PAGE_BITS-1:0]   start_q, start_d;
  logic [LEN_W-1:0]       creq_q, creq_d;
  logic [1:0]             bsect_q, bsect_d;

  logic                   done;
  logic [LEN_W-1:0]       done_cnt;
  logic                   done_restart;

  logic [LEN_W-1:0]       clip_req;
  logic                   clip_cut;

`ifdef HYPER_LSAB_DRAM_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]        wd_q, wd_d;
`endif

  hyper_lsab_dram_clip #(
    .COL_W (PAGE_BITS),
    .CNT_W (LEN_W)
  ) u_clip (
    .col     (addr_q[PAGE_BITS-1:0]),
    .len     (len_q),
    .req     (clip_req),
    .clipped (clip_cut)
  );

  // Next-state and next-output decode; completion and abort share one exit path.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    sect_d       = sect_q;
    old_d        = old_q;
    cnt_d        = cnt_q;
    restart_d    = restart_q;
    ready_d      = ready_q;
    mreq_d       = mreq_q;
    page_d       = page_q;
    issue_d      = 1'b0;
    start_d      = '0;
    creq_d       = '0;
    bsect_d      = '0;
    done         = 1'b0;
    done_cnt     = '0;
    done_restart = 1'b0;

    case (state_q)
      IDLE: begin
        if (GO && ready_q) begin
          addr_d    = NEW_ADDR;
          len_d     = BLOCK_LENGTH;
          sect_d    = NEW_SECTION;
          ready_d   = 1'b0;
          restart_d = 1'b0;
          if (BLOCK_LENGTH != '0) begin
            page_d  = NEW_ADDR[31:PAGE_BITS];
            mreq_d  = 1'b1;
            state_d = ALIGN;
          end else begin
            // Zero-length request completes through WBUSY one cycle later.
            state_d = WBUSY;
          end
        end
      end
      ALIGN: begin
        if (MCU_GRANT_ALIGN) begin
          issue_d = 1'b1;
          start_d = addr_q[PAGE_BITS-1:0];
          creq_d  = clip_req;
          bsect_d = sect_q;
          state_d = WSTART;
        end
      end
      WSTART: begin
        if (BLCK_WORKING) begin
          state_d = WBUSY;
        end
      end
      WBUSY: begin
        if (len_q == '0) begin
          done = 1'b1;
        end else if (!BLCK_WORKING) begin
          done         = 1'b1;
          done_cnt     = BLCK_COUNT_SENT;
          done_restart = clip_cut;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef HYPER_LSAB_DRAM_TIMEOUT_EN
    wd_d = '0;
    if (state_q == ALIGN || state_q == WSTART) begin
      wd_d = wd_q + WD_W'(1);
      if (wd_d == WD_W'(TIMEOUT_CYC)) begin
        done         = 1'b1;
        done_cnt     = '0;
        done_restart = 1'b1;
      end
    end
`endif

    if (done) begin
      cnt_d     = done_cnt;
      old_d     = addr_q + 32'(done_cnt);
      restart_d = done_restart;
      mreq_d    = 1'b0;
      ready_d   = 1'b1;
      issue_d   = 1'b0;
      start_d   = '0;
      creq_d    = '0;
      bsect_d   = '0;
      state_d   = IDLE;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      sect_q    <= '0;
      old_q     <= '0;
      cnt_q     <= '0;
      restart_q <= 1'b0;
      ready_q   <= 1'b1;
      mreq_q    <= 1'b0;
      page_q    <= '0;
      issue_q   <= 1'b0;
      start_q   <= '0;
      creq_q    <= '0;
      bsect_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      sect_q    <= sect_d;
      old_q     <= old_d;
      cnt_q     <= cnt_d;
      restart_q <= restart_d;
      ready_q   <= ready_d;
      mreq_q    <= mreq_d;
      page_q    <= page_d;
      issue_q   <= issue_d;
      start_q   <= start_d;
      creq_q    <= creq_d;
      bsect_q   <= bsect_d;
    end
  end

`ifdef HYPER_LSAB_DRAM_TIMEOUT_EN
  // Watchdog counter for the MCU grant and mover start waits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  assign OLD_ADDR          = old_q;
  assign READY             = ready_q;
  assign RESTART_OP        = restart_q;
  assign COUNT_SENT        = cnt_q;
  assign BLCK_START        = start_q;
  assign BLCK_COUNT_REQ    = creq_q;
  assign BLCK_ISSUE        = issue_q;
  assign BLCK_SECTION      = bsect_q;
  assign MCU_PAGE_ADDR     = page_q;
  assign MCU_REQUEST_ALIGN = mreq_q;

endmodule

// File: tb/tb_hyper_lsab_dram_ctrl.sv
// tb_hyper_lsab_dram_ctrl: table-driven bench with an MCU grant model, a mover model and
// issue/result scoreboards.
module tb_hyper_lsab_dram_ctrl;

  logic        CLK;
  logic        RST;
  logic        GO;
  logic [5:0]  BLOCK_LENGTH;
  logic [31:0] NEW_ADDR;
  logic [1:0]  NEW_SECTION;
  logic [31:0] OLD_ADDR;
  logic        READY;
  logic        RESTART_OP;
  logic [5:0]  COUNT_SENT;
  logic [11:0] BLCK_START;
  logic [5:0]  BLCK_COUNT_REQ;
  logic        BLCK_ISSUE;
  logic [1:0]  BLCK_SECTION;
  logic [5:0]  BLCK_COUNT_SENT;
  logic        BLCK_WORKING;
  logic [19:0] MCU_PAGE_ADDR;
  logic        MCU_REQUEST_ALIGN;
  logic        MCU_GRANT_ALIGN;

  hyper_lsab_dram_ctrl dut (
    .CLK               (CLK),
    .RST               (RST),
    .GO                (GO),
    .BLOCK_LENGTH      (BLOCK_LENGTH),
    .NEW_ADDR          (NEW_ADDR),
    .NEW_SECTION       (NEW_SECTION),
    .OLD_ADDR          (OLD_ADDR),
    .READY             (READY),
    .RESTART_OP        (RESTART_OP),
    .COUNT_SENT        (COUNT_SENT),
    .BLCK_START        (BLCK_START),
    .BLCK_COUNT_REQ    (BLCK_COUNT_REQ),
    .BLCK_ISSUE        (BLCK_ISSUE),
    .BLCK_SECTION      (BLCK_SECTION),
    .BLCK_COUNT_SENT   (BLCK_COUNT_SENT),
    .BLCK_WORKING      (BLCK_WORKING),
    .MCU_PAGE_ADDR     (MCU_PAGE_ADDR),
    .MCU_REQUEST_ALIGN (MCU_REQUEST_ALIGN),
    .MCU_GRANT_ALIGN   (MCU_GRANT_ALIGN)
  );

  typedef struct {
    logic [31:0] addr;
    logic [5:0]  len;
    logic [1:0]  sect;
    int          limit;
    int          gdly;
    logic [5:0]  exp_req;
    logic [5:0]  exp_cnt;
    logic        exp_rst;
    logic [31:0] exp_old;
    logic [19:0] exp_page;
  } vec_t;

  typedef struct {
    logic [11:0] start;
    logic [5:0]  req;
    logic [1:0]  sect;
  } iss_t;

  typedef struct {
    logic [5:0]  cnt;
    logic        rst;
    logic [31:0] old;
    logic [19:0] page;
    bit          chk_page;
  } res_t;

  iss_t iss_q[$];
  res_t res_q[$];
  vec_t vecs[8];

  int checks = 0;
  int errors = 0;
  int mover_limit = 63;
  int grant_delay = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // MCU model: grants grant_delay cycles after the request appears, drops with the request.
  initial begin
    int gcnt;
    gcnt = 0;
    MCU_GRANT_ALIGN = 1'b0;
    forever begin
      @(negedge CLK);
      #2;
      if (MCU_REQUEST_ALIGN === 1'b1) begin
        if (gcnt >= grant_delay) MCU_GRANT_ALIGN = 1'b1;
        gcnt++;
      end else begin
        MCU_GRANT_ALIGN = 1'b0;
        gcnt = 0;
      end
    end
  end

  // Mover model: busy for a few cycles after ISSUE, moves min(request, mover_limit) words.
  initial begin
    logic [5:0] r;
    BLCK_WORKING = 1'b0;
    BLCK_COUNT_SENT = '0;
    forever begin
      @(negedge CLK);
      if (BLCK_ISSUE === 1'b1) begin
        r = BLCK_COUNT_REQ;
        #2 BLCK_COUNT_SENT = '0;
        @(negedge CLK);
        #2 BLCK_WORKING = 1'b1;
        repeat (4) @(negedge CLK);
        #2;
        BLCK_COUNT_SENT = (int'(r) > mover_limit) ? 6'(mover_limit) : r;
        BLCK_WORKING = 1'b0;
      end
    end
  end

  // Monitor: pops the issue and result scoreboards when the DUT produces them.
  initial begin
    logic prev_ready, prev_issue, prev_grant;
    int   cyc, grise;
    iss_t ie;
    res_t re;
    prev_ready = 1'b1; prev_issue = 1'b0; prev_grant = 1'b0;
    cyc = 0; grise = -1;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RST !== 1'b0) begin
        prev_ready = 1'b1; prev_issue = 1'b0; prev_grant = 1'b0;
      end else begin
        if (MCU_GRANT_ALIGN === 1'b1 && !prev_grant) grise = cyc;
        if (BLCK_ISSUE === 1'b1) begin
          if (iss_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_issue: actual=1 required=0 at %0t", $time);
          end else begin
            ie = iss_q.pop_front();
            chk("issue_start", 32'(BLCK_START), 32'(ie.start));
            chk("issue_count_req", 32'(BLCK_COUNT_REQ), 32'(ie.req));
            chk("issue_section", 32'(BLCK_SECTION), 32'(ie.sect));
            chk("issue_after_grant", cyc, grise);
            chk("issue_ready_low", 32'(READY), 32'd0);
          end
        end
        if (prev_issue) begin
          chk("issue_one_cycle", 32'(BLCK_ISSUE), 32'd0);
          chk("mover_bus_idle", 32'({BLCK_START, BLCK_COUNT_REQ, BLCK_SECTION}), 32'd0);
        end
        if (!prev_ready && READY === 1'b1) begin
          if (res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready: actual=1 required=0 at %0t", $time);
          end else begin
            re = res_q.pop_front();
            chk("count_sent", 32'(COUNT_SENT), 32'(re.cnt));
            chk("restart_op", 32'(RESTART_OP), 32'(re.rst));
            chk("old_addr", OLD_ADDR, re.old);
            chk("mcu_req_dropped", 32'(MCU_REQUEST_ALIGN), 32'd0);
            if (re.chk_page) chk("mcu_page_addr", 32'(MCU_PAGE_ADDR), 32'(re.page));
          end
        end
        prev_ready = READY;
        prev_issue = BLCK_ISSUE;
        prev_grant = MCU_GRANT_ALIGN;
      end
    end
  end

  // Drive one request, push its expectations, and wait (bounded) for the result.
  task automatic run_vec(input vec_t v);
    bit ok;
    bit quiet;
    mover_limit  = v.limit;
    grant_delay  = v.gdly;
    NEW_ADDR     = v.addr;
    BLOCK_LENGTH = v.len;
    NEW_SECTION  = v.sect;
    GO           = 1'b1;
    if (v.len != 6'd0) iss_q.push_back('{start: v.addr[11:0], req: v.exp_req, sect: v.sect});
    res_q.push_back('{cnt: v.exp_cnt, rst: v.exp_rst, old: v.exp_old, page: v.exp_page,
                      chk_page: (v.len != 6'd0)});
    @(negedge CLK); #1;
    GO = 1'b0;
    chk("accept_ready_low", 32'(READY), 32'd0);
    chk("accept_restart_clear", 32'(RESTART_OP), 32'd0);
    if (v.len == 6'd0) begin
      @(negedge CLK); #1;
      chk("zero_len_ready_next", 32'(READY), 32'd1);
    end
    if (v.gdly >= 10) begin
      // Long grant wait: a new GO with other values must be ignored while busy.
      quiet = 1'b1;
      GO = 1'b1; NEW_ADDR = 32'hDEAD_BEEF; BLOCK_LENGTH = 6'd1;
      for (int i = 0; i < v.gdly - 2; i++) begin
        @(negedge CLK); #1;
        if (READY !== 1'b0 || BLCK_ISSUE !== 1'b0) quiet = 1'b0;
      end
      GO = 1'b0;
      chk("grant_wait_quiet", 32'(quiet), 32'd1);
    end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (READY === 1'b1 && res_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL transfer_timeout: actual=busy required=ready addr=0x%08h", v.addr);
      res_q.delete();
      iss_q.delete();
    end
  endtask

  initial begin
    bit ok;
    vec_t v;
    vecs[0] = '{32'h0020_0001,  6'd3, 2'd1, 63,  2,  6'd3,  6'd3, 1'b0, 32'h0020_0004, 20'h00200};
    vecs[1] = '{32'h0020_0FFF,  6'd3, 2'd2, 63,  0,  6'd1,  6'd1, 1'b1, 32'h0020_1000, 20'h00200};
    vecs[2] = '{32'h0020_1000,  6'd3, 2'd3,  1,  1,  6'd3,  6'd1, 1'b0, 32'h0020_1001, 20'h00201};
    vecs[3] = '{32'h0020_1001, 6'd63, 2'd0, 59,  3, 6'd63, 6'h3B, 1'b0, 32'h0020_103C, 20'h00201};
    vecs[4] = '{32'hFFFF_FFF0, 6'd20, 2'd1, 63,  0, 6'd16, 6'd16, 1'b1, 32'h0000_0000, 20'hFFFFF};
    vecs[5] = '{32'h0000_0FC1, 6'd63, 2'd2, 63,  1, 6'd63, 6'd63, 1'b0, 32'h0000_1000, 20'h00000};
    vecs[6] = '{32'h0000_0FC0, 6'd63, 2'd3, 63,  0, 6'd63, 6'd63, 1'b0, 32'h0000_0FFF, 20'h00000};
    vecs[7] = '{32'h0ABC_D010,  6'd5, 2'd1, 63, 20,  6'd5,  6'd5, 1'b0, 32'h0ABC_D015, 20'h0ABCD};

    RST = 1'b1; GO = 1'b0; BLOCK_LENGTH = '0; NEW_ADDR = '0; NEW_SECTION = '0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_ready", 32'(READY), 32'd1);
    chk("rst_results", {OLD_ADDR[25:0], COUNT_SENT}, 32'd0);
    chk("rst_restart", 32'(RESTART_OP), 32'd0);
    chk("rst_mover_bus", 32'({BLCK_ISSUE, BLCK_START, BLCK_COUNT_REQ, BLCK_SECTION}), 32'd0);
    chk("rst_mcu", 32'({MCU_REQUEST_ALIGN, MCU_PAGE_ADDR}), 32'd0);
    RST = 1'b0;
    @(negedge CLK); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while the mover is busy, then a zero-length request.
    mover_limit = 63; grant_delay = 0;
    NEW_ADDR = 32'h0030_0100; BLOCK_LENGTH = 6'd10; NEW_SECTION = 2'd1; GO = 1'b1;
    iss_q.push_back('{start: 12'h100, req: 6'd10, sect: 2'd1});
    @(negedge CLK); #1;
    GO = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (BLCK_WORKING === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK); #1;
    end
    chk("mid_xfer_mover_started", 32'(ok), 32'd1);
    @(negedge CLK); #1;
    chk("mid_xfer_busy", 32'(READY), 32'd0);
    RST = 1'b1;
    @(negedge CLK); #1;
    chk("mid_rst_ready", 32'(READY), 32'd1);
    chk("mid_rst_mcu", 32'({MCU_REQUEST_ALIGN, MCU_PAGE_ADDR}), 32'd0);
    chk("mid_rst_results", {OLD_ADDR[24:0], RESTART_OP, COUNT_SENT}, 32'd0);
    @(negedge CLK); #1;
    RST = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (BLCK_WORKING === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK); #1;
    end
    chk("mover_idle_after_rst", 32'(ok), 32'd1);
    @(negedge CLK); #1;
    v = '{32'h1234_5678, 6'd0, 2'd2, 63, 0, 6'd0, 6'd0, 1'b0, 32'h1234_5678, 20'h00000};
    run_vec(v);
    repeat (3) @(negedge CLK);
    chk("no_pending_issue", 32'(iss_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
